seg_scan_mux: RTL and testbench
===============================

Name: seg_scan_mux

Overview:
- Time-multiplexed scan driver for the two-digit seven-segment display. Sits directly downstream of the sign-magnitude digit decoder.
- Consumes the decoder's two active-low segment bytes: units and tens, with the minus sign carried on the units DP bit.
- Drives one shared segment bus plus two active-low digit enables, with anti-ghosting blank slots and frame-coherent input capture.

Parameters:
- DIV_W, 16, width of slot counter; each digit slot lasts 2^DIV_W clk cycles.
- BLANK_CYC, 4, blank-gap length in clk cycles between digit slots; legal range 1 to 2^DIV_W-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  scan enable; low freezes the scan and blanks the display.
- unidades  in  8  active-low segment pattern for the units digit, "a b c d e f g dp", with dp as minus sign.
- dezenas  in  8  active-low segment pattern for the tens digit.
- seg_out  out  8  shared active-low segment bus.
- anodo  out  2  active-low digit enables; bit0 = units, bit1 = tens.
- frame_tick  out  1  one-cycle pulse at start of each frame.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (immediate, no clock edge needed):
  - state=S_BLANK2, cnt=0, en_q=0.
  - shadow_uni=shadow_dez=8'hFF.
  - seg_out=8'hFF, anodo=2'b11, frame_tick=0.
- FSM cycle: S_UNI -> S_BLANK1 -> S_DEZ -> S_BLANK2 -> S_UNI.
- Digit states (S_UNI, S_DEZ):
  - cnt increments each enabled cycle.
  - At cnt==2^DIV_W-1: cnt<=0, advance to the next blank state.
- Blank states:
  - At cnt==BLANK_CYC-1: cnt<=0, advance to the next digit state.
- Frame period = 2*2^DIV_W + 2*BLANK_CYC cycles.
- Capture: on the edge entering S_UNI from S_BLANK2, shadow_uni<=unidades and shadow_dez<=dezenas. Inputs are ignored at all other times (no tearing). The first frame after reset starts after BLANK_CYC cycles.
- frame_tick: high exactly during the first cycle of each S_UNI.
- enable:
  - en_q registers enable.
  - While enable=0: cnt and state hold, frame_tick=0.
  - While en_q=0: seg_out=8'hFF and anodo=2'b11.
  - On re-enable the slot resumes at the held cnt; no restart.
- Outputs: driven from flops, updated on the same edge as state; no combinational path from inputs to outputs.
  - S_UNI: seg_out=shadow_uni, anodo=2'b10.
  - S_DEZ: seg_out=shadow_dez, anodo=2'b01.
  - Blank states: seg_out=8'hFF, anodo=2'b11.
- Exclusivity: the two anodo bits are never low simultaneously in any cycle, including across enable toggles and reset.
- Undefined inputs: X patterns from the decoder default branch are captured as-is. The bench checks only defined patterns.
- Reset mid-operation: immediate return to the reset values; previous shadow content is discarded.

Optional Feature:
- Macro: SCAN_ZERO_SUPPRESS_EN.
- Defined: if shadow_dez==8'h03 (tens digit "0"), the tens slot keeps anodo=2'b11 and seg_out=8'hFF. Slot timing is unchanged.
- Undefined: the tens "0" is displayed normally.

Test Plan:
1. Reset with DIV_W=4, BLANK_CYC=2: rst_n low with no clock -> seg_out=8'hFF, anodo=2'b11, frame_tick=0 immediately.
2. Scan order, unidades=8'h9F ("1") and dezenas=8'h25 ("2"), enable=1, after reset release:
   - 2 blank cycles.
   - anodo=10, seg_out=9F for 16 cycles.
   - 2 cycles 11/FF.
   - anodo=01, seg_out=25 for 16 cycles.
   - 2 cycles 11/FF.
   - frame_tick pulses every 36 cycles.
3. No tearing: change unidades to 8'h25 in cycle 5 of S_UNI -> seg_out stays 9F for the rest of the frame; 25 appears from the next frame_tick.
4. Freeze: enable=0 for 5 cycles at cnt=7 of S_UNI -> 5 cycles of FF/11 (shifted one cycle by en_q), then S_UNI resumes for its remaining 8 cycles; the frame lengthens by 5.
5. Reset mid S_DEZ: assert rst_n low between edges -> outputs blank asynchronously; after release, the first displayed units value is the newly captured one, never the stale shadow.
6. Zero suppression: dezenas=8'h03, unidades=8'h9E ("-1"):
   - With SCAN_ZERO_SUPPRESS_EN: tens slot shows anodo=11, seg_out=FF for 16 cycles.
   - Without: tens slot shows anodo=01, seg_out=03.
   - Units slot shows 9E in both builds.

Source files
------------

// File: rtl/seg_scan_mux_if.sv
// Bus between the digit decoder and the two-digit seven-segment scan driver.
// The decoder side uses the master modport; the scanner uses the slave modport.
interface seg_scan_mux_if;
    logic       enable;
    logic [7:0] unidades;
    logic [7:0] dezenas;
    logic [7:0] seg_out;
    logic [1:0] anodo;
    logic       frame_tick;

    modport master (
        output enable, unidades, dezenas,
        input  seg_out, anodo, frame_tick
    );

    modport slave (
        input  enable, unidades, dezenas,
        output seg_out, anodo, frame_tick
    );
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed scan driver for a two-digit active-low seven-segment display.
// Scan order: units slot, blank gap, tens slot, blank gap. Both digit patterns
// are captured together at the start of each frame so a frame never tears.
// Optional build macro: SCAN_ZERO_SUPPRESS_EN blanks a tens digit showing "0".
module seg_scan_mux #(
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned BLANK_CYC = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_scan_mux_if.slave bus
);

    typedef enum logic [1:0] {
        S_UNI,
        S_BLANK1,
        S_DEZ,
        S_BLANK2
    } state_t;

    localparam logic [DIV_W-1:0] SLOT_LAST  = '1;
    localparam logic [DIV_W-1:0] BLANK_LAST = DIV_W'(BLANK_CYC - 1);

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [1:0] AN_OFF    = 2'b11;
    localparam logic [1:0] AN_UNI    = 2'b10;
    localparam logic [1:0] AN_DEZ    = 2'b01;

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic             en_q;
    logic [7:0]       shadow_uni;
    logic [7:0]       shadow_dez;
    logic             dez_lit;

    // Decide whether the captured tens digit is lit during its slot.
`ifdef SCAN_ZERO_SUPPRESS_EN
    assign dez_lit = (shadow_dez != 8'h03);
`else
    assign dez_lit = 1'b1;
`endif

    // Scan FSM: slot timing, frame capture and registered display outputs.
    // Outputs are loaded with the pattern of the state being entered (or held),
    // so they change on the same edge as the state and never see the inputs
    // combinationally; a sampled-low enable forces the blank pattern instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_BLANK2;
            cnt            <= '0;
            en_q           <= 1'b0;
            shadow_uni     <= SEG_BLANK;
            shadow_dez     <= SEG_BLANK;
            bus.seg_out    <= SEG_BLANK;
            bus.anodo      <= AN_OFF;
            bus.frame_tick <= 1'b0;
        end else begin
            en_q           <= bus.enable;
            bus.frame_tick <= 1'b0;
            if (!bus.enable) begin
                bus.seg_out <= SEG_BLANK;
                bus.anodo   <= AN_OFF;
            end else begin
                case (state)
                    S_UNI: begin
                        if (cnt == SLOT_LAST) begin
                            cnt         <= '0;
                            state       <= S_BLANK1;
                            bus.seg_out <= SEG_BLANK;
                            bus.anodo   <= AN_OFF;
                        end else begin
                            cnt         <= cnt + 1'b1;
                            bus.seg_out <= shadow_uni;
                            bus.anodo   <= AN_UNI;
                        end
                    end
                    S_BLANK1: begin
                        if (cnt == BLANK_LAST) begin
                            cnt         <= '0;
                            state       <= S_DEZ;
                            bus.seg_out <= dez_lit ? shadow_dez : SEG_BLANK;
                            bus.anodo   <= dez_lit ? AN_DEZ : AN_OFF;
                        end else begin
                            cnt         <= cnt + 1'b1;
                            bus.seg_out <= SEG_BLANK;
                            bus.anodo   <= AN_OFF;
                        end
                    end
                    S_DEZ: begin
                        if (cnt == SLOT_LAST) begin
                            cnt         <= '0;
                            state       <= S_BLANK2;
                            bus.seg_out <= SEG_BLANK;
                            bus.anodo   <= AN_OFF;
                        end else begin
                            cnt         <= cnt + 1'b1;
                            bus.seg_out <= dez_lit ? shadow_dez : SEG_BLANK;
                            bus.anodo   <= dez_lit ? AN_DEZ : AN_OFF;
                        end
                    end
                    default: begin
                        if (cnt == BLANK_LAST) begin
                            cnt            <= '0;
                            state          <= S_UNI;
                            shadow_uni     <= bus.unidades;
                            shadow_dez     <= bus.dezenas;
                            bus.seg_out    <= bus.unidades;
                            bus.anodo      <= AN_UNI;
                            bus.frame_tick <= 1'b1;
                        end else begin
                            cnt         <= cnt + 1'b1;
                            bus.seg_out <= SEG_BLANK;
                            bus.anodo   <= AN_OFF;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux (DIV_W=4, BLANK_CYC=2).
// A frame-position model predicts the outputs every cycle; directed steps pin
// scan order, capture, freeze, reset and zero-suppression with literal values.
module tb_seg_scan_mux;

    localparam int SLOT  = 16;
    localparam int BL    = 2;
    localparam int FRAME = 2 * SLOT + 2 * BL;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic clk_run = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    seg_scan_mux_if bus ();

    seg_scan_mux #(.DIV_W(4), .BLANK_CYC(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 if (clk_run) clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: pos counts enabled edges since reset; pos 0 is the first units cycle.
    int         pos;
    logic [7:0] m_uni, m_dez;
    logic       m_enq, m_tick;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos    = -BL;
            m_uni  = 8'hFF;
            m_dez  = 8'hFF;
            m_enq  = 1'b0;
            m_tick = 1'b0;
        end else begin
            m_enq  = bus.enable;
            m_tick = 1'b0;
            if (bus.enable) begin
                pos++;
                if (pos >= 0 && pos % FRAME == 0) begin
                    m_uni  = bus.unidades;
                    m_dez  = bus.dezenas;
                    m_tick = 1'b1;
                end
            end
        end
    end

    function automatic void model_out(output logic [7:0] s, output logic [1:0] a);
        int ph;
        s = 8'hFF;
        a = 2'b11;
        if (m_enq && pos >= 0) begin
            ph = pos % FRAME;
            if (ph < SLOT) begin
                s = m_uni;
                a = 2'b10;
            end else if (ph >= SLOT + BL && ph < 2 * SLOT + BL) begin
`ifdef SCAN_ZERO_SUPPRESS_EN
                if (m_dez != 8'h03) begin
                    s = m_dez;
                    a = 2'b01;
                end
`else
                s = m_dez;
                a = 2'b01;
`endif
            end
        end
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic [7:0] es;
        logic [1:0] ea;
        model_out(es, ea);
        chk("seg_out", bus.seg_out, es);
        chk("anodo", bus.anodo, ea);
        chk("frame_tick", bus.frame_tick, m_tick);
        chk("anodo_exclusive", bus.anodo == 2'b00, 1'b0);
    end

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick(output int t);
        t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.frame_tick === 1'b1) begin
                t = cyc;
                break;
            end
        end
        chk("tick_timeout", t < 0, 1'b0);
    endtask

    int t0, t1, rel;
    logic [1:0] exp_an;
    logic [7:0] exp_seg;

    initial begin
        bus.enable   = 1'b0;
        bus.unidades = 8'h9F;
        bus.dezenas  = 8'h25;

        // Asynchronous reset with no clock running.
        #3 rst_n = 1'b0;
        #1;
        chk("reset_seg", bus.seg_out, 8'hFF);
        chk("reset_anodo", bus.anodo, 2'b11);
        chk("reset_tick", bus.frame_tick, 1'b0);
        clk_run = 1'b1;
        bus.enable = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        rel = cyc;

        // Scan order and frame period.
        wait_tick(t0);
        chk("first_frame_delay", t0 - rel, 2);
        chk("uni_seg", bus.seg_out, 8'h9F);
        chk("uni_anodo", bus.anodo, 2'b10);
        skip(16);
        chk("gap1_seg", bus.seg_out, 8'hFF);
        chk("gap1_anodo", bus.anodo, 2'b11);
        skip(2);
        chk("dez_seg", bus.seg_out, 8'h25);
        chk("dez_anodo", bus.anodo, 2'b01);
        wait_tick(t1);
        chk("frame_period", t1 - t0, 36);

        // No tearing: change mid units slot.
        skip(5);
        bus.unidades = 8'h25;
        skip(10);
        chk("no_tear_seg", bus.seg_out, 8'h9F);
        wait_tick(t0);
        chk("new_frame_seg", bus.seg_out, 8'h25);

        // Freeze for 5 cycles at cnt=7 of the units slot.
        skip(7);
        bus.enable = 1'b0;
        skip(1);
        chk("freeze_seg", bus.seg_out, 8'hFF);
        chk("freeze_anodo", bus.anodo, 2'b11);
        skip(4);
        bus.enable = 1'b1;
        skip(1);
        chk("resume_seg", bus.seg_out, 8'h25);
        chk("resume_anodo", bus.anodo, 2'b10);
        wait_tick(t1);
        chk("frozen_frame_period", t1 - t0, 41);

        // Tens zero, units "-1".
        bus.unidades = 8'h9E;
        bus.dezenas  = 8'h03;
        wait_tick(t0);
        chk("minus_one_seg", bus.seg_out, 8'h9E);
        skip(18);
`ifdef SCAN_ZERO_SUPPRESS_EN
        exp_seg = 8'hFF;
        exp_an  = 2'b11;
`else
        exp_seg = 8'h03;
        exp_an  = 2'b01;
`endif
        chk("zero_dez_seg", bus.seg_out, exp_seg);
        chk("zero_dez_anodo", bus.anodo, exp_an);

        // Reset in the middle of the tens slot.
        skip(4);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_seg", bus.seg_out, 8'hFF);
        chk("midreset_anodo", bus.anodo, 2'b11);
        bus.unidades = 8'hF9;
        skip(3);
        #2 rst_n = 1'b1;
        wait_tick(t0);
        chk("post_reset_capture", bus.seg_out, 8'hF9);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            #2;
            if ($urandom_range(0, 3) == 0) bus.unidades = 8'($urandom);
            if ($urandom_range(0, 3) == 0) bus.dezenas = ($urandom_range(0, 3) == 0) ? 8'h03 : 8'($urandom);
            bus.enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        skip(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
